// File: rtl/ramp_table_player.sv
// Multi-channel setpoint ramp engine: per-channel table RAM loaded over the register bus,
// replayed one sample per tick in one-shot or loop mode, started by run or by run+trig.
module ramp_table_player #(
  parameter int NUM_CHANS = 4,
  parameter int DATA_W    = 20,
  parameter int ADDR_W    = 13
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tbl_we,
  input  logic [$clog2(NUM_CHANS)-1:0]    tbl_chan,
  input  logic [ADDR_W-1:0]               tbl_addr,
  input  logic [DATA_W-1:0]               tbl_data,
  input  logic [NUM_CHANS*ADDR_W-1:0]     ramplen,
  input  logic [NUM_CHANS-1:0]            loop_en,
  input  logic [NUM_CHANS-1:0]            trig_en,
  input  logic [NUM_CHANS-1:0]            run,
  input  logic [NUM_CHANS-1:0]            abort,
  input  logic                            trig,
  input  logic                            tick,
  output logic [NUM_CHANS*DATA_W-1:0]     setpt,
  output logic [NUM_CHANS-1:0]            setpt_vld,
  output logic [NUM_CHANS-1:0]            active,
  output logic [NUM_CHANS-1:0]            done,
  output logic [NUM_CHANS-1:0]            wr_err
);

  localparam int CW    = $clog2(NUM_CHANS);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  for (genvar ch = 0; ch < NUM_CHANS; ch++) begin : g_chan
    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] len_q;
    logic              loop_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    logic              rd_last;
    logic [DATA_W-1:0] setpt_q;
    logic              vld_q;
    logic              last_q;
    logic              done_q;
    logic              err_q;
    logic              is_active;
    logic              we_ch;
    logic              play;
    logic              kill;

    assign is_active = (state != ST_IDLE);
    assign we_ch     = tbl_we && (tbl_chan == CW'(ch));
    assign play      = (state == ST_RUN) && tick && !abort[ch];
    assign kill      = is_active && abort[ch];

    // Table RAM: not reset, so contents survive a reset.
    always_ff @(posedge clk) begin
      if (we_ch && !is_active)
        mem[tbl_addr] <= tbl_data;
      if (play)
        rd_data <= mem[idx];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= ST_IDLE;
        idx     <= '0;
        len_q   <= '0;
        loop_q  <= 1'b0;
        rd_vld  <= 1'b0;
        rd_last <= 1'b0;
        setpt_q <= '0;
        vld_q   <= 1'b0;
        last_q  <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        rd_vld  <= play;
        rd_last <= play && (idx == len_q) && !loop_q;
        // Abort drops a sample still in the read stage so setpt keeps the last one played.
        vld_q   <= rd_vld && !kill;
        last_q  <= rd_vld && rd_last && !kill;
        if (rd_vld && !kill)
          setpt_q <= rd_data;
        done_q  <= last_q || kill;

        case (state)
          ST_IDLE: begin
            if (run[ch] && !abort[ch]) begin
              len_q  <= ramplen[ch*ADDR_W +: ADDR_W];
              loop_q <= loop_en[ch];
              idx    <= '0;
              err_q  <= 1'b0;
              state  <= trig_en[ch] ? ST_ARMED : ST_RUN;
            end
          end
          ST_ARMED: begin
            if (abort[ch]) begin
              state <= ST_IDLE;
              idx   <= '0;
            end else if (trig) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (abort[ch]) begin
              state <= ST_IDLE;
              idx   <= '0;
            end else if (tick) begin
              if (idx == len_q) begin
                idx <= '0;
                if (!loop_q)
                  state <= ST_IDLE;
              end else begin
                idx <= idx + ADDR_W'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase

        if (we_ch && is_active)
          err_q <= 1'b1;
      end
    end

    assign setpt[ch*DATA_W +: DATA_W] = setpt_q;
    assign setpt_vld[ch] = vld_q;
    assign active[ch]    = is_active;
    assign done[ch]      = done_q;
    assign wr_err[ch]    = err_q;
  end

endmodule

// File: tb/tb_ramp_table_player.sv
// Directed bench for ramp_table_player: expected samples are queued per channel as ticks are
// driven and checked against setpt when setpt_vld pulses.
module tb_ramp_table_player;

  localparam int NC = 4;
  localparam int DW = 20;
  localparam int AW = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic              tbl_we;
  logic [1:0]        tbl_chan;
  logic [AW-1:0]     tbl_addr;
  logic [DW-1:0]     tbl_data;
  logic [NC*AW-1:0]  ramplen;
  logic [NC-1:0]     loop_en;
  logic [NC-1:0]     trig_en;
  logic [NC-1:0]     run;
  logic [NC-1:0]     abort;
  logic              trig;
  logic              tick;
  logic [NC*DW-1:0]  setpt;
  logic [NC-1:0]     setpt_vld;
  logic [NC-1:0]     active;
  logic [NC-1:0]     done;
  logic [NC-1:0]     wr_err;

  ramp_table_player #(.NUM_CHANS(NC), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_chan(tbl_chan), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .ramplen(ramplen), .loop_en(loop_en), .trig_en(trig_en), .run(run),
    .abort(abort), .trig(trig), .tick(tick), .setpt(setpt), .setpt_vld(setpt_vld),
    .active(active), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned done_cnt [NC];
  logic [DW-1:0] exp_q [NC][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: sample outputs 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NC; c++) begin
      if (done[c]) done_cnt[c]++;
      if (setpt_vld[c]) begin
        if (exp_q[c].size() == 0)
          chk($sformatf("unexpected_vld_ch%0d", c), 32'(setpt[c*DW +: DW]), 32'hFFFF_FFFF);
        else
          chk($sformatf("setpt_ch%0d", c), 32'(setpt[c*DW +: DW]), 32'(exp_q[c].pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int c, input int a, input logic [DW-1:0] d);
    @(negedge clk);
    tbl_we = 1'b1; tbl_chan = 2'(c); tbl_addr = AW'(a); tbl_data = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic pulse(input logic [NC-1:0] r, input logic [NC-1:0] a,
                       input logic tk, input logic tg);
    @(negedge clk);
    run = r; abort = a; tick = tk; trig = tg;
    @(negedge clk);
    run = '0; abort = '0; tick = 1'b0; trig = 1'b0;
  endtask

  task automatic set_len(input int c, input int len);
    ramplen[c*AW +: AW] = AW'(len);
  endtask

  function automatic logic [31:0] sp(input int c);
    return 32'(setpt[c*DW +: DW]);
  endfunction

  initial begin
    int unsigned d0;
    reset = 1'b1; tbl_we = 1'b0; tbl_chan = '0; tbl_addr = '0; tbl_data = '0;
    ramplen = '0; loop_en = '0; trig_en = '0; run = '0; abort = '0; trig = 1'b0; tick = 1'b0;
    for (int c = 0; c < NC; c++) done_cnt[c] = 0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_setpt", setpt[31:0] | 32'(setpt[79:32] != '0), 32'h0);
    chk("rst_vld", 32'(setpt_vld), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_wr_err", 32'(wr_err), 32'h0);

    // 1: one-shot ch0, 0..100
    for (int i = 0; i <= 100; i++) wr(0, i, DW'(i));
    set_len(0, 100);
    pulse(4'b0001, '0, 1'b0, 1'b0);
    chk("t1_active", 32'(active[0]), 32'h1);
    for (int i = 0; i <= 100; i++) begin
      exp_q[0].push_back(DW'(i));
      pulse('0, '0, 1'b1, 1'b0);
    end
    cyc(5);
    chk("t1_done_cnt", done_cnt[0], 1);
    chk("t1_idle", 32'(active[0]), 32'h0);
    chk("t1_q_empty", exp_q[0].size(), 0);

    // 2: loop ch1, len 3
    wr(1, 0, 20'd10); wr(1, 1, 20'd20); wr(1, 2, 20'd30); wr(1, 3, 20'd40);
    set_len(1, 3); loop_en = 4'b0010;
    pulse(4'b0010, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_q[1].push_back(DW'(10 * ((i % 4) + 1)));
      pulse('0, '0, 1'b1, 1'b0);
    end
    cyc(4);
    chk("t2_no_done", done_cnt[1], 0);
    chk("t2_active", 32'(active[1]), 32'h1);
    pulse('0, 4'b0010, 1'b0, 1'b0);
    cyc(2);
    chk("t2_abort_done", done_cnt[1], 1);
    chk("t2_q_empty", exp_q[1].size(), 0);
    loop_en = '0;

    // 3: trigger-armed ch2, negative sample first
    wr(2, 0, 20'hFFFFB); wr(2, 1, 20'd7);
    set_len(2, 1); trig_en = 4'b0100;
    pulse(4'b0100, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) pulse('0, '0, 1'b1, 1'b0);
    cyc(3);
    chk("t3_armed_active", 32'(active[2]), 32'h1);
    pulse('0, '0, 1'b0, 1'b1);
    exp_q[2].push_back(20'hFFFFB);
    pulse('0, '0, 1'b1, 1'b0);
    exp_q[2].push_back(20'd7);
    pulse('0, '0, 1'b1, 1'b0);
    cyc(4);
    chk("t3_done_cnt", done_cnt[2], 1);
    chk("t3_idle", 32'(active[2]), 32'h0);
    trig_en = '0;

    // 4: write to running ch3 dropped, write to idle ch0 accepted
    wr(3, 0, 20'd100); wr(3, 1, 20'd200);
    set_len(3, 1); loop_en = 4'b1000;
    pulse(4'b1000, '0, 1'b0, 1'b0);
    wr(3, 0, 20'd999);
    wr(0, 0, 20'd555);
    chk("t4_err3", 32'(wr_err[3]), 32'h1);
    chk("t4_err0", 32'(wr_err[0]), 32'h0);
    for (int i = 0; i < 3; i++) begin
      exp_q[3].push_back((i % 2 == 0) ? 20'd100 : 20'd200);
      pulse('0, '0, 1'b1, 1'b0);
    end
    cyc(4);
    pulse('0, 4'b1000, 1'b0, 1'b0);
    cyc(2);
    chk("t4_err_sticky", 32'(wr_err[3]), 32'h1);
    loop_en = '0; trig_en = 4'b1000;
    pulse(4'b1000, '0, 1'b0, 1'b0);
    chk("t4_err_clr_on_run", 32'(wr_err[3]), 32'h0);
    pulse('0, 4'b1000, 1'b0, 1'b0);
    trig_en = '0;
    cyc(2);

    // 5: abort ch0 after 50 samples, then reset mid-ramp
    d0 = done_cnt[0];
    pulse(4'b0001, '0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      exp_q[0].push_back((i == 0) ? 20'd555 : DW'(i));
      pulse('0, '0, 1'b1, 1'b0);
    end
    cyc(4);
    chk("t5_setpt49", sp(0), 32'd49);
    pulse('0, 4'b0001, 1'b0, 1'b0);
    cyc(2);
    chk("t5_abort_done", done_cnt[0], d0 + 1);
    chk("t5_abort_idle", 32'(active[0]), 32'h0);
    chk("t5_setpt_hold", sp(0), 32'd49);
    pulse(4'b0001, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q[0].push_back((i == 0) ? 20'd555 : DW'(i));
      pulse('0, '0, 1'b1, 1'b0);
    end
    cyc(3);
    d0 = done_cnt[0];
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("t5_rst_setpt", sp(0), 32'h0);
    chk("t5_rst_active", 32'(active), 32'h0);
    cyc(3);
    chk("t5_rst_no_done", done_cnt[0], d0);

    // 6: ramplen 0 with exact timing; RAM survived reset
    set_len(0, 0);
    pulse(4'b0001, '0, 1'b0, 1'b0);
    exp_q[0].push_back(20'd555);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("t6_vld_early", 32'(setpt_vld[0]), 32'h0);
    @(negedge clk);
    chk("t6_vld_2clk", 32'(setpt_vld[0]), 32'h1);
    chk("t6_done_not_yet", 32'(done[0]), 32'h0);
    @(negedge clk);
    chk("t6_vld_gone", 32'(setpt_vld[0]), 32'h0);
    chk("t6_done", 32'(done[0]), 32'h1);
    @(negedge clk);
    chk("t6_done_pulse", 32'(done[0]), 32'h0);

    // run+abort same cycle stays idle, no done
    d0 = done_cnt[1];
    pulse(4'b0010, 4'b0010, 1'b0, 1'b0);
    cyc(2);
    chk("t6_run_abort_idle", 32'(active[1]), 32'h0);
    chk("t6_run_abort_nodone", done_cnt[1], d0);

    // tick with run: first sample waits for next tick
    set_len(2, 1);
    pulse(4'b0100, '0, 1'b1, 1'b0);
    cyc(3);
    exp_q[2].push_back(20'hFFFFB);
    pulse('0, '0, 1'b1, 1'b0);
    cyc(3);
    chk("t6_tick_run_q", exp_q[2].size(), 0);
    pulse('0, 4'b0100, 1'b0, 1'b0);
    cyc(3);

    for (int c = 0; c < NC; c++)
      chk($sformatf("final_q_empty_ch%0d", c), exp_q[c].size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
